// File: rtl/seq_mag_comp_pkg.sv
// Shared types for the sequential magnitude comparator: FSM states and the per-slice result.
// Optional build macro SEQ_MAG_COMP_SIGNED_EN adds two's-complement ordering (see seq_mag_comp).
package seq_mag_comp_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  typedef enum logic [1:0] {
    CmpLt,
    CmpEq,
    CmpGt
  } cmp_res_e;

  // Result packed as {L, E, G}.
  function automatic logic [2:0] to_leg(input cmp_res_e res);
    logic [2:0] leg;
    unique case (res)
      CmpLt:   leg = 3'b100;
      CmpEq:   leg = 3'b010;
      CmpGt:   leg = 3'b001;
      default: leg = 3'b010;
    endcase
    return leg;
  endfunction

endpackage

// File: rtl/seq_mag_comp_digit_comp.sv
// Combinational DIGIT-bit L/E/G slice comparator.
// With SEQ_MAG_COMP_SIGNED_EN, msb_invert_i flips each operand's top bit for two's-complement order.
module digit_comp
  import seq_mag_comp_pkg::*;
#(
  parameter int unsigned DIGIT = 8
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
`ifdef SEQ_MAG_COMP_SIGNED_EN
  input  logic             msb_invert_i,
`endif
  output cmp_res_e         res_o
);

  logic [DIGIT-1:0] flip;
  logic [DIGIT-1:0] a_eff;
  logic [DIGIT-1:0] b_eff;

  always_comb begin
    flip = '0;
`ifdef SEQ_MAG_COMP_SIGNED_EN
    flip[DIGIT-1] = msb_invert_i;
`endif
    a_eff = a_i ^ flip;
    b_eff = b_i ^ flip;
  end

  always_comb begin
    res_o = CmpEq;
    if (a_eff < b_eff) begin
      res_o = CmpLt;
    end else if (a_eff > b_eff) begin
      res_o = CmpGt;
    end
  end

endmodule

// File: rtl/seq_mag_comp.sv
// Multi-cycle WIDTH-bit magnitude comparator, one DIGIT slice per clock, MSB first, early exit.
// Build macro SEQ_MAG_COMP_SIGNED_EN adds the signed_mode input (two's-complement compare).
module seq_mag_comp
  import seq_mag_comp_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SEQ_MAG_COMP_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             busy,
  output logic             done,
  output logic             L,
  output logic             E,
  output logic             G
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned IdxW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IdxW-1:0] IdxTop = IdxW'(NDIG - 1);

  if ((WIDTH % DIGIT) != 0) begin : gen_width_check
    $error("seq_mag_comp: WIDTH must be a multiple of DIGIT");
  end

  state_e                      state_q;
  logic [NDIG-1:0][DIGIT-1:0]  a_q;
  logic [NDIG-1:0][DIGIT-1:0]  b_q;
  logic [IdxW-1:0]             idx_q;
  cmp_res_e                    slice_res;
  logic                        last_slice;

  assign busy       = (state_q == StRun);
  assign last_slice = (idx_q == '0);

`ifdef SEQ_MAG_COMP_SIGNED_EN
  logic signed_q;
  logic msb_invert;
  // Sign correction applies only to the most significant slice.
  assign msb_invert = signed_q && (idx_q == IdxTop);
`endif

  digit_comp #(
    .DIGIT        (DIGIT)
  ) u_digit_comp (
    .a_i          (a_q[idx_q]),
    .b_i          (b_q[idx_q]),
`ifdef SEQ_MAG_COMP_SIGNED_EN
    .msb_invert_i (msb_invert),
`endif
    .res_o        (slice_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      idx_q     <= '0;
      done      <= 1'b0;
      {L, E, G} <= 3'b000;
`ifdef SEQ_MAG_COMP_SIGNED_EN
      signed_q  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            idx_q    <= IdxTop;
            state_q  <= StRun;
`ifdef SEQ_MAG_COMP_SIGNED_EN
            signed_q <= signed_mode;
`endif
          end
        end
        StRun: begin
          if ((slice_res != CmpEq) || last_slice) begin
            {L, E, G} <= to_leg(slice_res);
            done      <= 1'b1;
            state_q   <= StIdle;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mag_comp.sv
// Self-checking bench for seq_mag_comp: directed cases plus randomized operands vs a reference model.
// Covers the signed path when SEQ_MAG_COMP_SIGNED_EN is defined.
module tb_seq_mag_comp;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DIGIT = 8;
  localparam int unsigned NDIG  = WIDTH / DIGIT;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic        busy;
  logic        done;
  logic        L;
  logic        E;
  logic        G;
`ifdef SEQ_MAG_COMP_SIGNED_EN
  logic        signed_mode = 1'b0;
`endif

  int          n_checks = 0;
  int          n_errors = 0;
  logic [2:0]  last_leg = 3'b000;

  seq_mag_comp #(
    .WIDTH       (WIDTH),
    .DIGIT       (DIGIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
`ifdef SEQ_MAG_COMP_SIGNED_EN
    .signed_mode (signed_mode),
`endif
    .busy        (busy),
    .done        (done),
    .L           (L),
    .E           (E),
    .G           (G)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Cycles needed: one per slice examined, stopping at the first differing slice.
  function automatic int ref_lat(input logic [31:0] x, input logic [31:0] y);
    int n = 0;
    for (int s = NDIG - 1; s >= 0; s--) begin
      n++;
      if (((x >> (s * DIGIT)) & 32'hFF) != ((y >> (s * DIGIT)) & 32'hFF)) break;
    end
    return n;
  endfunction

  function automatic logic [2:0] ref_leg(input logic [31:0] x, input logic [31:0] y,
                                         input logic sgn);
    if (sgn) begin
      if ($signed(x) < $signed(y)) return 3'b100;
      if ($signed(x) > $signed(y)) return 3'b001;
      return 3'b010;
    end
    if (x < y) return 3'b100;
    if (x > y) return 3'b001;
    return 3'b010;
  endfunction

  // Called #1 after an edge with the DUT idle; leaves the bench #1 after the done edge.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic sgn,
                        input string tag);
    int lat;
    int bc;
    a     = x;
    b     = y;
    start = 1'b1;
`ifdef SEQ_MAG_COMP_SIGNED_EN
    signed_mode = sgn;
`endif
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq({tag, "_busy_on_start"}, 32'(busy), 32'd1);
    check_eq({tag, "_done_low_on_start"}, 32'(done), 32'd0);
    check_eq({tag, "_leg_held"}, 32'({L, E, G}), 32'(last_leg));
    lat = 0;
    bc  = 0;
    while (!done && lat < 20) begin
      if (busy) bc++;
      a = $urandom;  // captured operands must be unaffected
      b = $urandom;
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'(ref_lat(x, y)));
    check_eq({tag, "_busy_cycles"}, 32'(bc), 32'(ref_lat(x, y)));
    check_eq({tag, "_leg"}, 32'({L, E, G}), 32'(ref_leg(x, y, sgn)));
    check_eq({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    last_leg = ref_leg(x, y, sgn);
  endtask

  initial begin
    int          lat;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] m;
    logic        sgn;
    int          j;
    int          gap;

    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_done", 32'(done), 32'd0);
    check_eq("reset_leg", 32'({L, E, G}), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op(32'h12345678, 32'h12345678, 1'b0, "t1_equal");
    @(posedge clk);
    #1;
    check_eq("t1_done_one_cycle", 32'(done), 32'd0);
    check_eq("t1_leg_hold", 32'({L, E, G}), 32'b010);
    run_op(32'h80000000, 32'h7FFFFFFF, 1'b0, "t2_msb");
    run_op(32'h000000FF, 32'h00000100, 1'b0, "t3_third");

    // Start while busy is ignored; then start on the done cycle is accepted.
    a     = 32'h5;
    b     = 32'h5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    a     = 32'hFFFFFFFF;
    b     = 32'h0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 2;
    while (!done && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq("t4_latency", 32'(lat), 32'd4);
    check_eq("t4_leg", 32'({L, E, G}), 32'b010);
    last_leg = 3'b010;
    run_op(32'h1, 32'h2, 1'b0, "t4_b2b");

    // Asynchronous reset mid-operation.
    a     = 32'h0;
    b     = 32'h0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_eq("t5_busy_abort", 32'(busy), 32'd0);
    check_eq("t5_leg_abort", 32'({L, E, G}), 32'd0);
    check_eq("t5_done_abort", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    check_eq("t5_no_done", 32'(done), 32'd0);
    rst      = 1'b0;
    last_leg = 3'b000;
    @(posedge clk);
    #1;
    check_eq("t5_idle_after_rst", 32'(busy), 32'd0);
    run_op(32'hDEAD0000, 32'hDEAD0001, 1'b0, "t5_after_rst");

`ifdef SEQ_MAG_COMP_SIGNED_EN
    run_op(32'h80000000, 32'h00000001, 1'b1, "t6_signed");
    run_op(32'h80000000, 32'h00000001, 1'b0, "t6_unsigned");
`endif

    // Random operands sharing a random number of leading slices.
    for (int it = 0; it < 60; it++) begin
      x   = $urandom;
      j   = $urandom_range(0, NDIG);
      m   = (j == 0) ? 32'h0 : (32'hFFFFFFFF << ((NDIG - j) * DIGIT));
      y   = (x & m) | ($urandom & ~m);
      sgn = 1'b0;
`ifdef SEQ_MAG_COMP_SIGNED_EN
      sgn = 1'($urandom_range(0, 1));
`endif
      run_op(x, y, sgn, "rand");
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
        check_eq("rand_done_pulse", 32'(done), 32'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seq_mag_comp.md
Name: seq_mag_comp

Overview:
Parametrised, multi-cycle magnitude comparator; successor to the team's single-cycle 8-bit L/E/G comparator.
- Compares two WIDTH-bit operands one DIGIT-bit slice per clock, MSB slice first.
- Terminates early at the first differing slice.
- Uses a start/busy/done handshake, so wide operands run without a wide combinational path inside datapath control logic.

Parameters:
WIDTH, 32, operand width in bits; must be a multiple of DIGIT (elaboration-time $error otherwise)
DIGIT, 8, bits compared per cycle; NDIG = WIDTH/DIGIT slices

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request a comparison; sampled only when busy=0
a  input  WIDTH  operand A, captured on the accepted start edge
b  input  WIDTH  operand B, captured on the accepted start edge
busy  output  1  high while a comparison is in progress
done  output  1  one-cycle pulse; L/E/G valid from this cycle
L  output  1  A < B
E  output  1  A == B
G  output  1  A > B

Behaviour:
- Reset and interface:
  - clk is the single clock; rst is asynchronous and active-high.
  - On rst: state=IDLE; busy, done, L, E, G all 0; operand registers cleared.
- States: IDLE, RUN. busy = (state==RUN), decoded from a register.
- IDLE:
  - start=1 at a rising edge captures a and b into internal registers.
  - Slice index idx is set to NDIG-1; state goes to RUN.
  - done deasserts on any edge where it was high.
- RUN, each edge:
  - Compare slice idx of A against slice idx of B using the digit_comp sub-module.
  - If the slices differ, or idx==0: register L/E/G from this slice's result, set done=1, return to IDLE.
  - Otherwise: idx decrements and state stays RUN.
- Latency: the number of slices examined, k in 1..NDIG.
  - done is high for exactly one cycle, after the k-th edge following the start edge.
  - Equal operands always take NDIG cycles.
- Result hold:
  - L/E/G keep their value until the next completed comparison.
  - They are not cleared on start.
  - Exactly one of L/E/G is high after the first done; all three are 0 only before the first done since reset.
- Simultaneous events:
  - start while busy=1 is ignored; operands are not recaptured.
  - start in the same cycle as done (state already IDLE at that edge) is accepted normally, giving back-to-back operation with a one-cycle minimum gap.
- Reset mid-operation: abort immediately. No done pulse; L/E/G forced to 0.
- Operand changes after capture have no effect.
- Arithmetic: default compare is unsigned.

Optional Feature:
- Macro: SEQ_MAG_COMP_SIGNED_EN.
- When defined:
  - Adds input port signed_mode (1 bit), captured with the operands on start.
  - With signed_mode=1, the MSB slice is compared with each operand's top bit inverted (two's-complement ordering); lower slices are compared unsigned.
  - With signed_mode=0, behaviour is identical to the unsigned design.
- When undefined: the port is absent and the compare is unsigned only.

Decomposition:
- Package seq_mag_comp_pkg holds:
  - the state enum (IDLE, RUN);
  - a cmp_res_t struct or enum {LT, EQ, GT} with its encoding onto L/E/G.
- Sub-module digit_comp: combinational DIGIT-bit L/E/G comparator.
  - Parameter DIGIT.
  - Optional msb_invert input, used only when SEQ_MAG_COMP_SIGNED_EN is defined.
  - One instance only.

Test Plan (WIDTH=32, DIGIT=8):
1. a=0x12345678, b=0x12345678, start pulse -> done after 4 cycles; E=1, L=0, G=0; busy high for 4 cycles.
2. a=0x80000000, b=0x7FFFFFFF -> done after 1 cycle; G=1 (unsigned); busy high for 1 cycle.
3. a=0x000000FF, b=0x00000100 -> done after 3 cycles; L=1.
4. Start a=0x00000005, b=0x00000005; at cycle 2, pulse start with a=0xFFFFFFFF, b=0 -> second start ignored; done after 4 cycles with E=1. Then start accepted on the done cycle with a=1, b=2 -> done 4 cycles later with L=1.
5. Start a=0, b=0, assert rst asynchronously mid-cycle at cycle 2 -> busy, L, E, G drop to 0 immediately; no done pulse; a new start after rst release completes normally.
6. With SEQ_MAG_COMP_SIGNED_EN, signed_mode=1, a=0x80000000, b=0x00000001 -> done after 1 cycle, L=1. Same operands with signed_mode=0 -> G=1.
